sobel_edge_detect_3x3: RTL and testbench
========================================

Name: sobel_edge_detect_3x3

Overview:
- Downstream consumer of the 3x3 8-bit window generator: takes p11..p33, vsync/href and the four edge flags, and computes a Sobel gradient magnitude per pixel.
- Emits a saturated 8-bit magnitude plus a thresholded binary edge bit, with timing-aligned vsync/href.
- Keeps a per-frame edge-pixel count for auto-threshold firmware.
- Feeds the binary/morphology stages of the video pipeline.

Parameters:
- CNT_W, 20, width of edge-pixel counters. 20 bits covers 640x480 = 307200.
- DEF_THRESH, 8'd64, threshold used after reset until the first frame start.

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- matrix_img_vsync  in  1  window-stream vsync
- matrix_img_href  in  1  window-stream href (one valid window per cycle)
- matrix_top_edge_flag  in  1  window centre on row 0
- matrix_bottom_edge_flag  in  1  window centre on last row
- matrix_left_edge_flag  in  1  window centre on column 0
- matrix_right_edge_flag  in  1  window centre on last column
- matrix_p11..matrix_p33  in  8 each  window pixels, row-major, p22 = centre
- cfg_thresh  in  8  edge threshold, asynchronous to frames
- post_img_vsync  out  1  aligned vsync
- post_img_href  out  1  aligned href
- post_img_gray  out  8  saturated |Gx|+|Gy|
- post_img_bit  out  1  1 = edge pixel
- frame_edge_cnt  out  CNT_W  edge-pixel count of the last completed frame
- frame_done  out  1  one-cycle pulse when frame_edge_cnt updates

Behaviour:
- Reset: all outputs, pipeline registers and counters = 0; threshold shadow = DEF_THRESH.
- Latency: fixed 4 cycles from a window input to its outputs. vsync, href and flags travel in a 4-deep shift register alongside the data.
- S1, border substitution, registered:
  - left flag: column 1 := column 2 (p11=p12, p21=p22, p31=p32).
  - right flag: column 3 := column 2.
  - top flag: row 1 := row 2.
  - bottom flag: row 3 := row 2.
  - Row substitution is applied after column substitution, so corners are consistent.
- S2, four 10-bit unsigned sums:
  - GxP = p13+2p23+p33
  - GxN = p11+2p21+p31
  - GyP = p31+2p32+p33
  - GyN = p11+2p12+p13
- S3: |Gx| = |GxP-GxN| and |Gy| = |GyP-GyN|, each 10-bit, range 0..1020.
- S4:
  - sum = |Gx|+|Gy|, 11-bit.
  - post_img_gray = (sum>255) ? 255 : sum[7:0].
  - post_img_bit = href_d4 & (sum >= thresh_shadow). The compare uses the unsaturated sum, zero-extended threshold.
- Data outputs when href is low: post_img_gray and post_img_bit are forced to 0. Pipeline registers may still toggle.
- Threshold shadow: loaded from cfg_thresh on the rising edge of matrix_img_vsync only. A mid-frame cfg_thresh change takes effect at the next frame start.
- Edge counter:
  - live_cnt increments when post_img_href & post_img_bit, saturating at all-ones.
  - On the falling edge of post_img_vsync: frame_edge_cnt := live_cnt (including a same-cycle increment), frame_done = 1 for one cycle, live_cnt := 0.
- Degenerate frames: a vsync pulse with no href yields frame_edge_cnt = 0 and still pulses frame_done.
- Reset mid-frame: everything returns to reset values. The first falling vsync after reset reports only pixels seen since reset.
- No backpressure: the input stream is accepted every cycle.

Optional Feature:
- Macro SOBEL_BORDER_ZERO_EN.
- Defined: S1 performs no substitution. A "border" bit (OR of the four flags) travels down the pipe; bordered pixels output gray = 0 and bit = 0, and are not counted.
- Undefined: replication as specified in Behaviour.

Decomposition:
- Shared package holds: pixel width (8), sum width (10), magnitude width (11), the saturation constant 255, and a struct/typedef bundling vsync/href/4 flags for the delay line.
- One natural sub-module: sobel_abs_diff, registered |a-b| on 10 bits, instantiated twice in S3.

Test Plan:
- Uniform window, all pixels = 100, no flags, thresh 64 -> post_img_gray = 0 and bit = 0, four cycles later.
- Vertical step: column 1 = 0, columns 2 and 3 = 255 -> sum = 1020, gray = 255, bit = 1. Same window with right flag -> column 3 replaced by column 2 (255) -> Gx = 1020, bit = 1. Column 1 = 0, column 2 = 0, column 3 = 255 with right flag -> gray = 0.
- Column 3 = 10, rest 0:
  - cfg_thresh = 40 loaded at vsync rise -> gray = 40, bit = 1.
  - cfg_thresh = 41 -> bit = 0.
  - cfg_thresh changed to 41 mid-frame -> bit stays 1 until the next frame.
- Left flag with columns 2 and 3 = 0, column 1 = 200 -> column 1 replaced -> gray = 0. With SOBEL_BORDER_ZERO_EN defined, any flagged window -> gray = 0, bit = 0.
- 8x4 frame containing exactly 5 edge windows -> frame_edge_cnt = 5 and one-cycle frame_done after post_img_vsync falls; next frame with 0 edges -> 0.
- Reset asserted mid-frame -> all outputs 0 immediately; next full frame counts correctly; bit-width saturation checked by forcing live_cnt near all-ones.

Source files
------------

// File: rtl/sobel_edge_detect_3x3_pkg.sv
// Shared widths, constants, window/control types and arithmetic helpers for the Sobel stage.
// Latency: none (types and pure functions only).
// Backpressure: none.
package sobel_edge_detect_3x3_pkg;

  localparam int PIX_W = 8;   // pixel width
  localparam int SUM_W = 10;  // a+2b+c of three pixels, max 1020
  localparam int MAG_W = 11;  // |Gx|+|Gy|, max 2040
  localparam logic [PIX_W-1:0] SAT_MAX = 8'd255;

  typedef logic [PIX_W-1:0] pix_t;
  typedef logic [SUM_W-1:0] sum_t;
  typedef logic [MAG_W-1:0] mag_t;

  // win[row][col]; row 0 is the top row, col 0 the left column
  typedef pix_t [2:0][2:0] win_t;

  // Control bundle carried down the delay line next to the pixel data
  typedef struct packed {
    logic vsync;
    logic href;
    logic top;
    logic bottom;
    logic left;
    logic right;
  } ctrl_t;

  // a + 2b + c, computed at the sum width so it cannot overflow
  function automatic sum_t wsum(input pix_t a, input pix_t b, input pix_t c);
    return SUM_W'(a) + SUM_W'({b, 1'b0}) + SUM_W'(c);
  endfunction

  // Clamp a gradient magnitude to the 8-bit pixel range
  function automatic pix_t sat_pix(input mag_t m);
    return (m > MAG_W'(SAT_MAX)) ? SAT_MAX : m[PIX_W-1:0];
  endfunction

endpackage

// File: rtl/sobel_edge_detect_3x3_if.sv
// Window-stream input, edge-stream output and frame statistics of the Sobel stage.
// Latency: none (wiring only).
// Backpressure: none; the stream has no ready signal.
// master: window source / result sink (drives matrix_*, cfg_thresh).
// slave : Sobel core (drives post_img_*, frame_edge_cnt, frame_done).
interface sobel_edge_detect_3x3_if #(
  parameter int CNT_W = 20
);
  import sobel_edge_detect_3x3_pkg::*;

  logic             matrix_img_vsync;
  logic             matrix_img_href;
  logic             matrix_top_edge_flag;
  logic             matrix_bottom_edge_flag;
  logic             matrix_left_edge_flag;
  logic             matrix_right_edge_flag;
  pix_t             matrix_p11, matrix_p12, matrix_p13;
  pix_t             matrix_p21, matrix_p22, matrix_p23;
  pix_t             matrix_p31, matrix_p32, matrix_p33;
  pix_t             cfg_thresh;

  logic             post_img_vsync;
  logic             post_img_href;
  pix_t             post_img_gray;
  logic             post_img_bit;
  logic [CNT_W-1:0] frame_edge_cnt;
  logic             frame_done;

  modport master (
    output matrix_img_vsync, matrix_img_href,
    output matrix_top_edge_flag, matrix_bottom_edge_flag,
    output matrix_left_edge_flag, matrix_right_edge_flag,
    output matrix_p11, matrix_p12, matrix_p13,
    output matrix_p21, matrix_p22, matrix_p23,
    output matrix_p31, matrix_p32, matrix_p33,
    output cfg_thresh,
    input  post_img_vsync, post_img_href, post_img_gray, post_img_bit,
    input  frame_edge_cnt, frame_done
  );

  modport slave (
    input  matrix_img_vsync, matrix_img_href,
    input  matrix_top_edge_flag, matrix_bottom_edge_flag,
    input  matrix_left_edge_flag, matrix_right_edge_flag,
    input  matrix_p11, matrix_p12, matrix_p13,
    input  matrix_p21, matrix_p22, matrix_p23,
    input  matrix_p31, matrix_p32, matrix_p33,
    input  cfg_thresh,
    output post_img_vsync, post_img_href, post_img_gray, post_img_bit,
    output frame_edge_cnt, frame_done
  );

endinterface

// File: rtl/sobel_abs_diff.sv
// Registered absolute difference |a-b| of two unsigned gradient half-sums.
// Latency: 1 cycle.
// Backpressure: none; a new pair is accepted every cycle.
// Ports: clk, rst_n (async active-low), a_dat/b_dat operands, abs_q registered result.
module sobel_abs_diff
  import sobel_edge_detect_3x3_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  sum_t a_dat,
  input  sum_t b_dat,
  output sum_t abs_q
);

  sum_t abs_d;

  always_comb begin
    abs_d = (a_dat >= b_dat) ? (a_dat - b_dat) : (b_dat - a_dat);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      abs_q <= '0;
    end else begin
      abs_q <= abs_d;
    end
  end

endmodule

// File: rtl/sobel_edge_detect_3x3.sv
// Sobel |Gx|+|Gy| per 3x3 window: saturated gray, thresholded edge bit, per-frame edge count.
// Latency: 4 cycles window-in to post_img_* out; frame_done one cycle after post_img_vsync falls.
// Backpressure: none; one window is accepted every cycle.
// Ports: clk, rst_n (async active-low), bus (slave modport: window stream in, edge stream and
// frame statistics out). Build option SOBEL_BORDER_ZERO_EN: no border replication; windows
// with any edge flag produce gray=0, bit=0 and are not counted.
module sobel_edge_detect_3x3
  import sobel_edge_detect_3x3_pkg::*;
#(
  parameter int         CNT_W      = 20,
  parameter logic [7:0] DEF_THRESH = 8'd64
) (
  input logic                  clk,
  input logic                  rst_n,
  sobel_edge_detect_3x3_if.slave bus
);

  ctrl_t            ctrl_in;
  ctrl_t [3:0]      ctrl_d, ctrl_q;  // [0] aligned with S1 ... [3] aligned with outputs
  win_t             win_in, win_d, win_q;
  sum_t             gxp_d, gxn_d, gyp_d, gyn_d;
  sum_t             gxp_q, gxn_q, gyp_q, gyn_q;
  sum_t             gx_abs, gy_abs;
  mag_t             mag;
  logic             border;
  pix_t             gray_d, gray_q;
  logic             bit_d, bit_q;
  pix_t             thresh_d, thresh_q;
  logic             vsync_in_d, vsync_in_q;
  logic             post_vsync_d, post_vsync_q;
  logic             edge_hit, post_fall;
  logic [CNT_W-1:0] live_inc;
  logic [CNT_W-1:0] live_d, live_q;
  logic [CNT_W-1:0] frame_cnt_d, frame_cnt_q;
  logic             frame_done_d, frame_done_q;
  logic             unused_tail_flags;

  assign ctrl_in = '{vsync:  bus.matrix_img_vsync,
                     href:   bus.matrix_img_href,
                     top:    bus.matrix_top_edge_flag,
                     bottom: bus.matrix_bottom_edge_flag,
                     left:   bus.matrix_left_edge_flag,
                     right:  bus.matrix_right_edge_flag};

  assign win_in[0][0] = bus.matrix_p11;
  assign win_in[0][1] = bus.matrix_p12;
  assign win_in[0][2] = bus.matrix_p13;
  assign win_in[1][0] = bus.matrix_p21;
  assign win_in[1][1] = bus.matrix_p22;
  assign win_in[1][2] = bus.matrix_p23;
  assign win_in[2][0] = bus.matrix_p31;
  assign win_in[2][1] = bus.matrix_p32;
  assign win_in[2][2] = bus.matrix_p33;

  // S1: border substitution
  always_comb begin
    win_d = win_in;
`ifndef SOBEL_BORDER_ZERO_EN
    for (int r = 0; r < 3; r++) begin
      if (ctrl_in.left)  win_d[r][0] = win_d[r][1];
      if (ctrl_in.right) win_d[r][2] = win_d[r][1];
    end
    // Rows after columns, so a corner window copies the already-replicated column
    if (ctrl_in.top)    win_d[0] = win_d[1];
    if (ctrl_in.bottom) win_d[2] = win_d[1];
`endif
  end

  // S2: positive/negative half-sums of the two kernels
  always_comb begin
    gxp_d = wsum(win_q[0][2], win_q[1][2], win_q[2][2]);
    gxn_d = wsum(win_q[0][0], win_q[1][0], win_q[2][0]);
    gyp_d = wsum(win_q[2][0], win_q[2][1], win_q[2][2]);
    gyn_d = wsum(win_q[0][0], win_q[0][1], win_q[0][2]);
  end

  // S3: registered magnitudes
  sobel_abs_diff u_abs_gx (
    .clk   (clk),
    .rst_n (rst_n),
    .a_dat (gxp_q),
    .b_dat (gxn_q),
    .abs_q (gx_abs)
  );

  sobel_abs_diff u_abs_gy (
    .clk   (clk),
    .rst_n (rst_n),
    .a_dat (gyp_q),
    .b_dat (gyn_q),
    .abs_q (gy_abs)
  );

  // S4: magnitude, saturation and threshold on the unsaturated sum
  always_comb begin
    mag = MAG_W'(gx_abs) + MAG_W'(gy_abs);
`ifdef SOBEL_BORDER_ZERO_EN
    border = ctrl_q[2].top | ctrl_q[2].bottom | ctrl_q[2].left | ctrl_q[2].right;
`else
    border = 1'b0;
`endif
    gray_d = '0;
    bit_d  = 1'b0;
    if (ctrl_q[2].href && !border) begin
      gray_d = sat_pix(mag);
      bit_d  = (mag >= MAG_W'(thresh_q));
    end
  end

  // Control delay line and the frame-synchronous threshold shadow
  always_comb begin
    ctrl_d     = {ctrl_q[2:0], ctrl_in};
    vsync_in_d = ctrl_in.vsync;
    thresh_d   = (ctrl_in.vsync && !vsync_in_q) ? bus.cfg_thresh : thresh_q;
  end

  // Edge counter; a hit in the same cycle as the vsync fall belongs to the closing frame
  always_comb begin
    edge_hit     = ctrl_q[3].href & bit_q;
    post_vsync_d = ctrl_q[3].vsync;
    post_fall    = post_vsync_q & ~ctrl_q[3].vsync;
    live_inc     = (&live_q) ? live_q : live_q + CNT_W'(edge_hit);
    live_d       = live_inc;
    frame_cnt_d  = frame_cnt_q;
    frame_done_d = 1'b0;
    if (post_fall) begin
      live_d       = '0;
      frame_cnt_d  = live_inc;
      frame_done_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q       <= '0;
      win_q        <= '0;
      gxp_q        <= '0;
      gxn_q        <= '0;
      gyp_q        <= '0;
      gyn_q        <= '0;
      gray_q       <= '0;
      bit_q        <= 1'b0;
      thresh_q     <= DEF_THRESH;
      vsync_in_q   <= 1'b0;
      post_vsync_q <= 1'b0;
      live_q       <= '0;
      frame_cnt_q  <= '0;
      frame_done_q <= 1'b0;
    end else begin
      ctrl_q       <= ctrl_d;
      win_q        <= win_d;
      gxp_q        <= gxp_d;
      gxn_q        <= gxn_d;
      gyp_q        <= gyp_d;
      gyn_q        <= gyn_d;
      gray_q       <= gray_d;
      bit_q        <= bit_d;
      thresh_q     <= thresh_d;
      vsync_in_q   <= vsync_in_d;
      post_vsync_q <= post_vsync_d;
      live_q       <= live_d;
      frame_cnt_q  <= frame_cnt_d;
      frame_done_q <= frame_done_d;
    end
  end

  // The flags have no consumer once they reach the output stage
  assign unused_tail_flags = ^{ctrl_q[3].top, ctrl_q[3].bottom, ctrl_q[3].left, ctrl_q[3].right};

  assign bus.post_img_vsync = ctrl_q[3].vsync;
  assign bus.post_img_href  = ctrl_q[3].href;
  assign bus.post_img_gray  = gray_q;
  assign bus.post_img_bit   = bit_q;
  assign bus.frame_edge_cnt = frame_cnt_q;
  assign bus.frame_done     = frame_done_q;

endmodule

// File: tb/tb_sobel_edge_detect_3x3.sv
module tb_sobel_edge_detect_3x3;
  import sobel_edge_detect_3x3_pkg::*;

  // Narrow counter so saturation is reachable with small frames
  localparam int TB_CNT_W = 4;
  localparam int CNT_MAX  = (1 << TB_CNT_W) - 1;
  localparam int DEF_THR  = 64;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sobel_edge_detect_3x3_if #(.CNT_W(TB_CNT_W)) bus ();

  sobel_edge_detect_3x3 #(.CNT_W(TB_CNT_W), .DEF_THRESH(8'd64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Current input drive
  int cur_px[9];
  bit cur_t, cur_b, cur_l, cur_r, cur_vs, cur_hs;
  int cur_cfg;

  // Reference model state
  typedef struct { bit vs; bit hs; int sum; bit border; } exp_t;
  exp_t expq[$];
  int m_thr, m_live, m_fec;
  bit m_done, m_in_vs_prev, m_post_vs_prev;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [8:0][7:0] px;
    logic [3:0]      flags;  // {top, bottom, left, right}
    int              thr;
    int              gray;
    bit              bitv;
  } vec_t;
  vec_t vecs[13];

  function automatic int model_sum(input int px[9], input bit ft, input bit fb,
                                   input bit fl, input bit fr);
    int w[3][3];
    int gx, gy;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) w[r][c] = px[r*3+c];
`ifndef SOBEL_BORDER_ZERO_EN
    for (int r = 0; r < 3; r++) begin
      if (fl) w[r][0] = w[r][1];
      if (fr) w[r][2] = w[r][1];
    end
    for (int c = 0; c < 3; c++) begin
      if (ft) w[0][c] = w[1][c];
      if (fb) w[2][c] = w[1][c];
    end
`endif
    gx = (w[0][2] + 2*w[1][2] + w[2][2]) - (w[0][0] + 2*w[1][0] + w[2][0]);
    gy = (w[2][0] + 2*w[2][1] + w[2][2]) - (w[0][0] + 2*w[0][1] + w[0][2]);
    if (gx < 0) gx = -gx;
    if (gy < 0) gy = -gy;
    return gx + gy;
  endfunction

  function automatic logic [8:0][7:0] cols(input int a, input int b, input int c);
    logic [8:0][7:0] p;
    for (int r = 0; r < 3; r++) begin
      p[r*3+0] = 8'(a); p[r*3+1] = 8'(b); p[r*3+2] = 8'(c);
    end
    return p;
  endfunction

  function automatic logic [8:0][7:0] rows(input int a, input int b, input int c);
    logic [8:0][7:0] p;
    for (int k = 0; k < 3; k++) begin
      p[0+k] = 8'(a); p[3+k] = 8'(b); p[6+k] = 8'(c);
    end
    return p;
  endfunction

  task automatic model_reset();
    expq.delete();
    for (int i = 0; i < 3; i++) expq.push_back('{vs: 1'b0, hs: 1'b0, sum: 0, border: 1'b0});
    m_thr = DEF_THR; m_live = 0; m_fec = 0;
    m_done = 1'b0; m_in_vs_prev = 1'b0; m_post_vs_prev = 1'b0;
  endtask

  task automatic drive_bus();
    bus.matrix_img_vsync        = cur_vs;
    bus.matrix_img_href         = cur_hs;
    bus.matrix_top_edge_flag    = cur_t;
    bus.matrix_bottom_edge_flag = cur_b;
    bus.matrix_left_edge_flag   = cur_l;
    bus.matrix_right_edge_flag  = cur_r;
    bus.matrix_p11 = 8'(cur_px[0]); bus.matrix_p12 = 8'(cur_px[1]); bus.matrix_p13 = 8'(cur_px[2]);
    bus.matrix_p21 = 8'(cur_px[3]); bus.matrix_p22 = 8'(cur_px[4]); bus.matrix_p23 = 8'(cur_px[5]);
    bus.matrix_p31 = 8'(cur_px[6]); bus.matrix_p32 = 8'(cur_px[7]); bus.matrix_p33 = 8'(cur_px[8]);
    bus.cfg_thresh = 8'(cur_cfg);
  endtask

  // One clock: drive, advance, check the output stream and counter against the model
  task automatic tick();
    exp_t e, o;
    bit   exp_bit, fall;
    int   exp_gray, nxt;
    drive_bus();
    e.vs = cur_vs;
    e.hs = cur_hs;
    e.sum = model_sum(cur_px, cur_t, cur_b, cur_l, cur_r);
`ifdef SOBEL_BORDER_ZERO_EN
    e.border = cur_t | cur_b | cur_l | cur_r;
`else
    e.border = 1'b0;
`endif
    expq.push_back(e);
    @(posedge clk);
    #1;
    o = expq.pop_front();
    exp_bit  = o.hs && !o.border && (o.sum >= m_thr);
    exp_gray = (o.hs && !o.border) ? ((o.sum > 255) ? 255 : o.sum) : 0;
    tests++;
    if (bus.post_img_vsync !== o.vs || bus.post_img_href !== o.hs ||
        int'(bus.post_img_gray) != exp_gray || bus.post_img_bit !== exp_bit) begin
      fails++;
      $display("FAIL stream @%0t: got vs=%0b hs=%0b gray=%0d bit=%0b, want vs=%0b hs=%0b gray=%0d bit=%0b",
               $time, bus.post_img_vsync, bus.post_img_href, bus.post_img_gray, bus.post_img_bit,
               o.vs, o.hs, exp_gray, exp_bit);
    end
    tests++;
    if (bus.frame_done !== m_done || int'(bus.frame_edge_cnt) != m_fec) begin
      fails++;
      $display("FAIL counter @%0t: got done=%0b cnt=%0d, want done=%0b cnt=%0d",
               $time, bus.frame_done, bus.frame_edge_cnt, m_done, m_fec);
    end
    nxt = m_live + ((o.hs && exp_bit) ? 1 : 0);
    if (nxt > CNT_MAX) nxt = CNT_MAX;
    fall = m_post_vs_prev && !o.vs;
    if (fall) begin
      m_fec = nxt; m_live = 0; m_done = 1'b1;
    end else begin
      m_live = nxt; m_done = 1'b0;
    end
    m_post_vs_prev = o.vs;
    if (cur_vs && !m_in_vs_prev) m_thr = cur_cfg;
    m_in_vs_prev = cur_vs;
  endtask

  task automatic set_idle();
    for (int k = 0; k < 9; k++) cur_px[k] = 0;
    {cur_t, cur_b, cur_l, cur_r} = 4'b0;
    cur_vs = 1'b0;
    cur_hs = 1'b0;
  endtask

  task automatic load_win(input logic [8:0][7:0] px, input logic [3:0] flags);
    for (int k = 0; k < 9; k++) cur_px[k] = int'(px[k]);
    {cur_t, cur_b, cur_l, cur_r} = flags;
  endtask

  task automatic frame_start(input int cfg);
    set_idle();
    cur_cfg = cfg;
    cur_vs = 1'b1;
    tick();
    tick();
    cur_vs = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    tests++;
    if (bus.post_img_vsync !== 1'b0 || bus.post_img_href !== 1'b0 || bus.post_img_gray !== 8'd0 ||
        bus.post_img_bit !== 1'b0 || bus.frame_done !== 1'b0 || bus.frame_edge_cnt !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got vs=%0b hs=%0b gray=%0d bit=%0b done=%0b cnt=%0d, want all 0",
               bus.post_img_vsync, bus.post_img_href, bus.post_img_gray, bus.post_img_bit,
               bus.frame_done, bus.frame_edge_cnt);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  // Idle until frame_done (bounded), then check the reported count and the pulse width
  task automatic wait_done(input int want, input bit check);
    bit seen = 1'b0;
    int cnt  = -1;
    set_idle();
    for (int i = 0; i < 12 && !seen; i++) begin
      tick();
      if (bus.frame_done === 1'b1) begin
        seen = 1'b1;
        cnt  = int'(bus.frame_edge_cnt);
      end
    end
    if (check) begin
      tests++;
      if (!seen || cnt != want) begin
        fails++;
        $display("FAIL frame_cnt: got seen=%0b cnt=%0d, want seen=1 cnt=%0d", seen, cnt, want);
      end
      tick();
      tests++;
      if (bus.frame_done !== 1'b0) begin
        fails++;
        $display("FAIL done_pulse: got done=%0b one cycle later, want 0", bus.frame_done);
      end
    end
  endtask

  // 8x4 frame body; mode 0 = no edges, 1 = five edges, 2 = every window an edge
  task automatic send_frame(input int mode);
    bit is_edge;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 8; c++) begin
        int idx = r*8 + c;
        is_edge = (mode == 2) ||
                  (mode == 1 && (idx == 3 || idx == 9 || idx == 14 || idx == 20 || idx == 31));
        load_win(is_edge ? cols(0, 255, 255) : cols(100, 100, 100), 4'b0000);
        cur_hs = 1'b1;
        tick();
      end
      set_idle();
      tick();
      tick();
    end
  endtask

  task automatic check_out(input string name, input int gray, input bit bitv);
    tests++;
    if (int'(bus.post_img_gray) != gray || bus.post_img_bit !== bitv) begin
      fails++;
      $display("FAIL %s: got gray=%0d bit=%0b, want gray=%0d bit=%0b",
               name, bus.post_img_gray, bus.post_img_bit, gray, bitv);
    end
  endtask

  initial begin
    rst_n = 1'b1;
    cur_cfg = DEF_THR;
    set_idle();
    drive_bus();
    #2;
    do_reset();

    vecs[0]  = '{cols(100, 100, 100), 4'b0000, 64,  0,   1'b0};
    vecs[1]  = '{cols(0, 255, 255),   4'b0000, 64,  255, 1'b1};
    vecs[2]  = '{cols(0, 255, 255),   4'b0001, 64,  255, 1'b1};
    vecs[3]  = '{cols(0, 0, 255),     4'b0001, 64,  0,   1'b0};
    vecs[4]  = '{cols(0, 0, 10),      4'b0000, 40,  40,  1'b1};
    vecs[5]  = '{cols(0, 0, 10),      4'b0000, 41,  40,  1'b0};
    vecs[6]  = '{cols(200, 0, 0),     4'b0010, 64,  0,   1'b0};
    vecs[7]  = '{rows(200, 0, 0),     4'b1000, 64,  0,   1'b0};
    vecs[8]  = '{rows(0, 255, 255),   4'b0000, 64,  255, 1'b1};
    vecs[9]  = '{cols(0, 0, 64),      4'b0000, 64,  255, 1'b1};
    vecs[10] = '{cols(0, 0, 63),      4'b0000, 255, 252, 1'b0};
    vecs[11] = '{rows(0, 0, 255),     4'b0100, 64,  0,   1'b0};
    vecs[12] = '{72'd255,             4'b1010, 64,  0,   1'b0};
`ifdef SOBEL_BORDER_ZERO_EN
    vecs[2].gray = 0;
    vecs[2].bitv = 1'b0;
`endif

    // Single windows, each in its own frame so its threshold is loaded at vsync rise
    for (int i = 0; i < 13; i++) begin
      frame_start(vecs[i].thr);
      load_win(vecs[i].px, vecs[i].flags);
      cur_hs = 1'b1;
      tick();
      set_idle();
      repeat (3) tick();
      check_out($sformatf("vec%0d", i), vecs[i].gray, vecs[i].bitv);
    end

    // Mid-frame threshold change is held off until the next frame start
    frame_start(40);
    load_win(cols(0, 0, 10), 4'b0000);
    cur_hs = 1'b1;
    tick();
    set_idle();
    cur_cfg = 41;
    tick();
    load_win(cols(0, 0, 10), 4'b0000);
    cur_hs = 1'b1;
    tick();
    set_idle();
    repeat (3) tick();
    check_out("thr_midframe_hold", 40, 1'b1);
    frame_start(41);
    load_win(cols(0, 0, 10), 4'b0000);
    cur_hs = 1'b1;
    tick();
    set_idle();
    repeat (3) tick();
    check_out("thr_next_frame", 40, 1'b0);

    // Frame edge counting: 5 edges, 0 edges, saturation, degenerate frame
    frame_start(64);
    wait_done(0, 1'b0);
    send_frame(1);
    frame_start(64);
    wait_done(5, 1'b1);
    send_frame(0);
    frame_start(64);
    wait_done(0, 1'b1);
    send_frame(2);
    frame_start(64);
    wait_done(CNT_MAX, 1'b1);
    frame_start(64);
    wait_done(0, 1'b1);

    // Reset in the middle of a frame, then a clean frame
    send_frame(0);
    for (int i = 0; i < 3; i++) begin
      load_win(cols(0, 255, 255), 4'b0000);
      cur_hs = 1'b1;
      tick();
    end
    do_reset();
    frame_start(64);
    wait_done(0, 1'b1);
    send_frame(1);
    frame_start(64);
    wait_done(5, 1'b1);

    // Randomized frames against the model
    for (int cyc = 0; cyc < 600; cyc++) begin
      cur_vs  = (cyc % 50) < 2;
      cur_hs  = ((cyc % 50) >= 4) && ($urandom_range(0, 3) != 0);
      cur_cfg = $urandom_range(0, 255);
      for (int k = 0; k < 9; k++) cur_px[k] = $urandom_range(0, 255);
      if ($urandom_range(0, 3) == 0)
        for (int k = 0; k < 9; k++) cur_px[k] = (k % 3 == 0) ? $urandom_range(0, 30) : cur_px[k];
      cur_t = ($urandom_range(0, 7) == 0);
      cur_b = ($urandom_range(0, 7) == 0);
      cur_l = ($urandom_range(0, 7) == 0);
      cur_r = ($urandom_range(0, 7) == 0);
      tick();
    end
    set_idle();
    repeat (8) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
